// File: rtl/smart_bus_drain.sv
// Drains one row of smart MACs onto the shared smart bus, one column per cycle,
// into a first-word-fall-through output FIFO that throttles the drain when full.
module smart_bus_drain #(
    parameter int WORD_SIZE  = 16,
    parameter int NUM_COLS   = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    output logic [NUM_COLS-1:0]                select_right_out_smart,
    input  logic [WORD_SIZE-1:0]               horizontal_smart_bus_in,
    output logic                               busy,
    output logic                               done,
    output logic [WORD_SIZE-1:0]               out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(NUM_COLS);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [IW-1:0] LAST_COL = IW'(NUM_COLS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_nx_s;
    logic [IW-1:0]          col_idx_r;
    logic [IW-1:0]          col_nx_s;
    logic [PW-1:0]          wr_ptr_r;
    logic [PW-1:0]          rd_ptr_r;
    logic [CW-1:0]          count_r;
    logic [CW-1:0]          count_nx_s;
    logic [WORD_SIZE-1:0]   mem_r [FIFO_DEPTH];
    logic [NUM_COLS-1:0]    sel_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   push_s;
    logic                   pop_s;

    function automatic logic [NUM_COLS-1:0] col_onehot(input logic [IW-1:0] idx);
        col_onehot = NUM_COLS'(1) << idx;
    endfunction

    // Space is judged on the occupancy at the start of the cycle, so a pop never enables a push.
    assign push_s = (state_r == DRAIN) && (count_r < DEPTH_C);
    assign pop_s  = (count_r != {CW{1'b0}}) && out_ready;

    // Next-state, next-column and next-occupancy computation.
    always_comb begin
        state_nx_s = state_r;
        col_nx_s   = col_idx_r;
        count_nx_s = count_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = DRAIN;
                    col_nx_s   = {IW{1'b0}};
                end else begin
                    state_nx_s = IDLE;
                end
            end
            DRAIN: begin
                if (push_s && (col_idx_r == LAST_COL)) begin
                    state_nx_s = DONE;
                end else if (push_s) begin
                    col_nx_s = col_idx_r + IW'(1);
                end else begin
                    col_nx_s = col_idx_r;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
        case ({push_s, pop_s})
            2'b10:   count_nx_s = count_r + CW'(1);
            2'b01:   count_nx_s = count_r - CW'(1);
            default: count_nx_s = count_r;
        endcase
    end

    // FSM with registered select/busy/done, derived from the values taking effect at this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            col_idx_r <= {IW{1'b0}};
            sel_r     <= {NUM_COLS{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            col_idx_r <= col_nx_s;
            busy_r    <= (state_nx_s != IDLE);
            done_r    <= (state_nx_s == DONE);
            sel_r     <= ((state_nx_s == DRAIN) && (count_nx_s < DEPTH_C)) ?
                         col_onehot(col_nx_s) : {NUM_COLS{1'b0}};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since the depth is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            count_r <= count_nx_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end
    end

    // FIFO storage; contents are meaningless while the matching count is zero, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= horizontal_smart_bus_in;
        end
    end

    assign select_right_out_smart = sel_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign out_data   = mem_r[rd_ptr_r];
    assign out_valid  = (count_r != {CW{1'b0}});
    assign fifo_count = count_r;

endmodule

// File: tb/tb_smart_bus_drain.sv
// Randomised and directed bench for smart_bus_drain; a queue-based model of the
// row drain and output FIFO is compared against the DUT on every falling edge.
module tb_smart_bus_drain;

    localparam int NC = 6;
    localparam int FD = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic [NC-1:0] sel;
    logic [15:0]   bus;
    logic          busy;
    logic          done;
    logic [15:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    fifo_count;

    smart_bus_drain #(.WORD_SIZE(16), .NUM_COLS(NC), .FIFO_DEPTH(FD)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .start                   (start),
        .select_right_out_smart  (sel),
        .horizontal_smart_bus_in (bus),
        .busy                    (busy),
        .done                    (done),
        .out_data                (out_data),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .fifo_count              (fifo_count)
    );

    int checks = 0;
    int failures = 0;

    // Model: phase 0 idle, 1 draining, 2 done; queue holds the words in the FIFO.
    int          m_phase = 0;
    int          m_col = 0;
    logic [15:0] mq[$];
    logic [15:0] base = 16'h0000;

    logic [15:0]   got[$];
    logic [NC-1:0] sel_hist[$];
    int            done_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Each column drives base+column onto the bus while it is selected.
    always_comb begin
        bus = 16'hBAD0;
        for (int c = 0; c < NC; c++) begin
            if (sel[c]) bus = base + 16'(c);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [NC-1:0] exp_sel;
        exp_sel = (m_phase == 1 && mq.size() < FD) ? (NC'(1) << m_col) : '0;
        check("select", 32'(sel), 32'(exp_sel));
        check("select_onehot0", 32'($onehot0(sel)), 32'd1);
        check("busy", 32'(busy), 32'(m_phase != 0));
        check("done", 32'(done), 32'(m_phase == 2));
        check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        check("fifo_count", 32'(fifo_count), 32'(mq.size()));
        if (mq.size() != 0) check("out_data", 32'(out_data), 32'(mq[0]));
    endtask

    task automatic cycle(input logic st, input logic rdy);
        bit pop;
        bit push;
        @(negedge clk);
        compare_all();
        if (sel != '0) sel_hist.push_back(sel);
        if (done) done_cnt++;
        if (out_valid && rdy) got.push_back(out_data);
        start = st;
        out_ready = rdy;
        if (rst) begin
            pop  = (mq.size() != 0) && rdy;
            push = (m_phase == 1) && (mq.size() < FD);
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(base + 16'(m_col));
            case (m_phase)
                0: if (st) begin m_phase = 1; m_col = 0; end
                1: if (push) begin
                       if (m_col == NC - 1) m_phase = 2;
                       else m_col++;
                   end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        compare_all();
        #2 rst = 1'b0;
        #1;
        check("rst_select", 32'(sel), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        mq.delete();
        got.delete();
        m_phase = 0;
        m_col = 0;
        start = 1'b0;
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
    endtask

    task automatic run_until_idle(input logic rdy, input int budget);
        for (int i = 0; i < budget; i++) begin
            cycle(1'b0, rdy);
            if (m_phase == 0 && mq.size() == 0) return;
        end
        check("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic clear_obs();
        got.delete();
        sel_hist.delete();
        done_cnt = 0;
    endtask

    task automatic check_stream(input string nm, input logic [15:0] b);
        check({nm, "_words"}, 32'(got.size()), 32'(NC));
        for (int k = 0; k < got.size() && k < NC; k++)
            check({nm, "_word"}, 32'(got[k]), 32'(b + 16'(k)));
        check({nm, "_done_pulses"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("init_select", 32'(sel), 32'd0);
        check("init_count", 32'(fifo_count), 32'd0);
        check("init_valid", 32'(out_valid), 32'd0);
        check("init_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Basic drain with a free-flowing consumer.
        clear_obs();
        base = 16'h0A00;
        cycle(1'b1, 1'b1);
        run_until_idle(1'b1, 40);
        check_stream("basic", 16'h0A00);
        check("basic_selects", 32'(sel_hist.size()), 32'(NC));
        for (int k = 0; k < sel_hist.size(); k++)
            check("basic_select_seq", 32'(sel_hist[k]), 32'(1) << k);

        // Backpressure: FIFO fills, drain stalls, then resumes after one pop-only cycle.
        clear_obs();
        base = 16'h0B00;
        cycle(1'b1, 1'b0);
        repeat (6) cycle(1'b0, 1'b0);
        check("bp_full_count", 32'(fifo_count), 32'd4);
        check("bp_full_select", 32'(sel), 32'd0);
        check("bp_full_busy", 32'(busy), 32'd1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        check("bp_pop_only_count", 32'(fifo_count), 32'd3);
        check("bp_resume_select", 32'(sel), 32'h10);
        run_until_idle(1'b1, 40);
        check_stream("bp", 16'h0B00);

        // Repeated start while draining is ignored.
        clear_obs();
        base = 16'h0C00;
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        run_until_idle(1'b1, 40);
        check_stream("restart", 16'h0C00);

        // Reset after two pushes aborts the drain without a done pulse.
        clear_obs();
        base = 16'h0D00;
        cycle(1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0);
        check("mid_count", 32'(fifo_count), 32'd2);
        do_reset();
        check("mid_no_done", 32'(done_cnt), 32'd0);
        clear_obs();
        base = 16'h0E00;
        cycle(1'b1, 1'b1);
        run_until_idle(1'b1, 40);
        check_stream("post_rst", 16'h0E00);
        if (sel_hist.size() != 0) check("post_rst_first_col", 32'(sel_hist[0]), 32'd1);
        else check("post_rst_first_col", 32'd0, 32'd1);

        // Random traffic: back-to-back drains, toggling ready, occasional resets.
        for (int i = 0; i < 600; i++) begin
            if (m_phase == 0 && $urandom_range(0, 3) == 0) base = 16'($urandom);
            if ($urandom_range(0, 200) == 0) do_reset();
            else cycle($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
        end
        run_until_idle(1'b1, 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/smart_bus_drain.md
SMART_BUS_DRAIN -- requirements
Module: smart_bus_drain

Interface
REQ-001 Parameter: WORD_SIZE, default 16, width of one smart-bus word.
REQ-002 Parameter: NUM_COLS, default 4, number of smart MACs in the served row (>=2).
REQ-003 Parameter: FIFO_DEPTH, default 8, output buffer entries (power of 2, >=2).
REQ-004 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous, active-low.
REQ-006 Port: start  input  1  one-cycle request to drain the whole row.
REQ-007 Port: select_right_out_smart  output  NUM_COLS  one-hot-or-zero; bit c drives column c's right-out-onto-smart-bus select.
REQ-008 Port: horizontal_smart_bus_in  input  WORD_SIZE  row smart bus value arriving at the array edge.
REQ-009 Port: busy  output  1  high while a drain is in progress (not IDLE).
REQ-010 Port: done  output  1  one-cycle pulse when a drain completes.
REQ-011 Port: out_data  output  WORD_SIZE  FIFO head word (first-word-fall-through).
REQ-012 Port: out_valid  output  1  FIFO non-empty.
REQ-013 Port: out_ready  input  1  downstream accepts out_data when out_valid && out_ready.
REQ-014 Port: fifo_count  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

Function
REQ-015 FSM states: IDLE, DRAIN, DONE.
REQ-016 IDLE -> DRAIN when start=1; col_idx SHALL load 0.
REQ-017 start SHALL be ignored in DRAIN and DONE.
REQ-018 In DRAIN, the cycle is a push cycle iff fifo_count < FIFO_DEPTH at the start of that cycle; a pop in the same cycle SHALL NOT free space for that cycle's push.
REQ-019 Push cycle: select_right_out_smart = one-hot bit col_idx; horizontal_smart_bus_in sampled at that cycle's rising edge is written to FIFO tail; col_idx increments.
REQ-020 Stall cycle (FIFO full): select_right_out_smart = 0; no write; col_idx holds.
REQ-021 Columns SHALL be drained in ascending order 0..NUM_COLS-1; each column is pushed exactly once per drain.
REQ-022 DRAIN -> DONE on the push cycle with col_idx = NUM_COLS-1.
REQ-023 DONE: done=1 for exactly one cycle, select_right_out_smart=0; next state IDLE.
REQ-024 select_right_out_smart SHALL be 0 in IDLE and DONE, and never have more than one bit set.
REQ-025 busy = 1 in DRAIN and DONE, 0 in IDLE.
REQ-026 Pop: when out_valid && out_ready, head pointer advances; pop SHALL be independent of the FSM and allowed in any state.
REQ-027 Simultaneous push and pop: fifo_count unchanged; data order preserved.
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH; out_valid = (fifo_count != 0).
REQ-029 out_data is don't-care when out_valid=0; while out_valid=1 and out_ready=0, out_data SHALL hold.
REQ-030 Latency: a word pushed at edge k SHALL be visible on out_data with out_valid=1 after edge k when the FIFO was empty.

Reset
REQ-031 rst=0 SHALL asynchronously force: state IDLE, col_idx=0, FIFO pointers and fifo_count=0, busy=0, done=0, out_valid=0, select_right_out_smart=0.
REQ-032 Reset asserted mid-drain SHALL abort the drain; FIFO contents discarded; no done pulse.
REQ-033 After rst deasserts, the block SHALL require a new start pulse.

Verification
REQ-034 Basic drain: defaults, out_ready=1, start pulse, bus shows 0x0A00+c when bit c selected -> select bits 0001,0010,0100,1000 on 4 consecutive cycles; out_data stream 0x0A00..0x0A03; done one cycle after last push.
REQ-035 Backpressure: FIFO_DEPTH=2, out_ready=0 -> 2 pushes, select=0 while full, fifo_count=2; raise out_ready -> remaining 2 words pushed, all 4 words delivered in order.
REQ-036 Full with simultaneous pop: count=FIFO_DEPTH, out_ready=1 -> that cycle pops only, count=FIFO_DEPTH-1, push resumes next cycle.
REQ-037 Wrap-around: FIFO_DEPTH=4, three back-to-back drains with out_ready toggling 1/0 -> all 12 words in order, fifo_count never exceeds 4.
REQ-038 Reset mid-drain: rst=0 after 2 pushes -> select=0, out_valid=0, fifo_count=0 immediately; no done; start afterwards drains from column 0.
REQ-039 start while busy: second start during DRAIN -> ignored; exactly NUM_COLS pushes and one done pulse.
